painel_andar: RTL



---
 rtl/painel_pkg.sv | 24 ++
 rtl/decod_7seg.sv | 36 +++
 rtl/painel_andar.sv | 124 ++++++++++++
 3 files changed

// File: rtl/painel_pkg.sv
// rtl/painel_pkg.sv - shared types and segment constants for the floor panel
package painel_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } estado_t;

  // Bit order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/decod_7seg.sv
// rtl/decod_7seg.sv - decimal digit to active-high seven-segment decoder
module decod_7seg
  import painel_pkg::*;
(
  input  logic [3:0] digito,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  logic [6:0] seg;

  always_comb begin
    seg = SEG_BLANK;
    case (digito)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: rtl/painel_andar.sv
// rtl/painel_andar.sv - elevator floor panel: floor counter, direction FSM, door blink, 7-seg display
module painel_andar
  import painel_pkg::*;
#(
  parameter  int NUM_ANDARES  = 4,
  parameter  int BLINK_CICLOS = 25_000_000,
  localparam int W            = (NUM_ANDARES > 2) ? $clog2(NUM_ANDARES) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pulso_sobe,
  input  logic         pulso_desce,
  input  logic         porta_aberta,
  output logic [W-1:0] andar,
  output logic         a,
  output logic         b,
  output logic         c,
  output logic         d,
  output logic         e,
  output logic         f,
  output logic         g,
  output logic         subindo,
  output logic         descendo,
  output logic         erro
);

  localparam int           CW        = $clog2(BLINK_CICLOS);
  localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_CICLOS - 1);
  localparam logic [W-1:0]  TOPO      = W'(NUM_ANDARES - 1);

  estado_t       estado, estado_prox;
  logic [W-1:0]  andar_prox;
  logic          erro_prox;
  logic [CW-1:0] contador, contador_prox;
  logic          fase, fase_prox;
  logic          so_sobe, so_desce, movimento_ok;
  logic          da, db, dc, dd, de, df, dg;

  assign so_sobe      = pulso_sobe & ~pulso_desce;
  assign so_desce     = pulso_desce & ~pulso_sobe;
  // Door request wins over any pulse in the same cycle.
  assign movimento_ok = (estado != PORTA) & ~porta_aberta;

  always_comb begin
    estado_prox   = estado;
    andar_prox    = andar;
    erro_prox     = erro;
    contador_prox = '0;
    fase_prox     = 1'b1;

    if (pulso_sobe & pulso_desce)
      erro_prox = 1'b1;

    if (porta_aberta) begin
      estado_prox = PORTA;
    end else if (estado == PORTA) begin
      estado_prox = PARADO;
    end

    if (estado == PORTA) begin
      if (pulso_sobe | pulso_desce)
        erro_prox = 1'b1;
    end else if (movimento_ok) begin
      if (so_sobe) begin
        if (andar < TOPO) begin
          andar_prox  = andar + 1'b1;
          estado_prox = SUBINDO;
        end else begin
          erro_prox = 1'b1;
        end
      end else if (so_desce) begin
        if (andar > '0) begin
          andar_prox  = andar - 1'b1;
          estado_prox = DESCENDO;
        end else begin
          erro_prox = 1'b1;
        end
      end
    end

    // Counting only while staying in PORTA; entry or exit restarts at phase on.
    if ((estado == PORTA) && (estado_prox == PORTA)) begin
      if (contador == BLINK_MAX) begin
        contador_prox = '0;
        fase_prox     = ~fase;
      end else begin
        contador_prox = contador + 1'b1;
        fase_prox     = fase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= PARADO;
      andar    <= '0;
      erro     <= 1'b0;
      contador <= '0;
      fase     <= 1'b1;
    end else begin
      estado   <= estado_prox;
      andar    <= andar_prox;
      erro     <= erro_prox;
      contador <= contador_prox;
      fase     <= fase_prox;
    end
  end

  decod_7seg u_decod (
    .digito (4'(andar)),
    .a      (da),
    .b      (db),
    .c      (dc),
    .d      (dd),
    .e      (de),
    .f      (df),
    .g      (dg)
  );

  assign {a, b, c, d, e, f, g} = fase ? {da, db, dc, dd, de, df, dg} : SEG_BLANK;
  assign subindo  = (estado == SUBINDO);
  assign descendo = (estado == DESCENDO);

endmodule
